// File: rtl/piso_sr.sv
// piso_sr: parallel-in serial-out shift register, transmit end of the
// serial shift-register link. Accepts a WIDTH-bit word via a load/ready
// handshake and shifts it out one bit per clock. The default order is MSB first,
// to suit a left-shifting receiver that takes its serial input into bit 0.
// Back-to-back words go out with no gap. so_last marks the frame boundary.
//
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// (XOR of the loaded word) after the data bits. In that build so_last moves
// to the parity cycle and ready stays low during the last data bit.
module piso_sr #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] pi,
   input  logic             load,
   output logic             ready,
   output logic             so,
   output logic             so_valid,
   output logic             so_last,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;
`else
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             accept;
`ifdef PISO_PARITY_EN
   logic             parBit_q, parBit_d;
`endif

   // Output decode: every output comes from registered state only, so there is no path from pi or load to any output
   always_comb begin
      so      = 1'b0;
      so_last = 1'b0;
      busy    = (state_q != IDLE);
      unique case (state_q)
         SHIFT: begin
            so = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
`ifndef PISO_PARITY_EN
            so_last = (cnt_q == '0);
`endif
         end
`ifdef PISO_PARITY_EN
         PAR: begin
            so      = parBit_q;
            so_last = 1'b1;
         end
`endif
         default: begin
            so      = 1'b0;
            so_last = 1'b0;
         end
      endcase
      so_valid = busy;
      ready    = (state_q == IDLE) || so_last;
   end

   // A word is taken only while the block is ready; a load at any other time is ignored
   assign accept = load && ready;

   // Next-state logic: load on accept, shift toward the output end with zero fill, and finish or chain the frame on the last bit
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
      parBit_d = parBit_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               shreg_d = pi;
               cnt_d   = CW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
               parBit_d = ^pi;
`endif
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
               if (MSB_FIRST) begin
                  shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               end else begin
                  shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
               end
            end else begin
`ifdef PISO_PARITY_EN
               state_d = PAR;
`else
               if (accept) begin
                  state_d = SHIFT;
                  shreg_d = pi;
                  cnt_d   = CW'(WIDTH - 1);
               end else begin
                  state_d = IDLE;
               end
`endif
            end
         end
`ifdef PISO_PARITY_EN
         PAR: begin
            if (accept) begin
               state_d  = SHIFT;
               shreg_d  = pi;
               cnt_d    = CW'(WIDTH - 1);
               parBit_d = ^pi;
            end else begin
               state_d = IDLE;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers: clear aborts any frame in progress immediately, without a clock
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
`ifdef PISO_PARITY_EN
         parBit_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
         parBit_q <= parBit_d;
`endif
      end
   end

endmodule

// File: tb/tb_piso_sr.sv
// tb_piso_sr: directed self-checking bench for piso_sr at WIDTH=4.
// In the default build it runs with MSB_FIRST=1 and covers reset, a single frame,
// back-to-back frames, an ignored load and a mid-frame clear.
// With PISO_PARITY_EN defined it runs with MSB_FIRST=0 and covers a parity frame
// with a loopback receiver.
module tb_piso_sr;

`ifdef PISO_PARITY_EN
   localparam bit MSB = 1'b0;
`else
   localparam bit MSB = 1'b1;
`endif

   logic       clk;
   logic       clear;
   logic [3:0] pi;
   logic       load;
   logic       ready;
   logic       so;
   logic       so_valid;
   logic       so_last;
   logic       busy;

   int checks = 0;
   int errors = 0;

   piso_sr #(.WIDTH(4), .MSB_FIRST(MSB)) dut (
      .clk      (clk),
      .clear    (clear),
      .pi       (pi),
      .load     (load),
      .ready    (ready),
      .so       (so),
      .so_valid (so_valid),
      .so_last  (so_last),
      .busy     (busy)
   );

   // Free-running clock with a 10-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: count it and report any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ld, input logic [3:0] word);
      load = ld;
      pi   = word;
   endtask

   // Advance to just after the next rising edge so outputs are sampled away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check every output for one cycle
   task automatic checkCycle(input string tag, input logic eSo, input logic eValid,
                             input logic eLast, input logic eReady);
      checkOutput({tag, " so"},    32'(so),       32'(eSo));
      checkOutput({tag, " valid"}, 32'(so_valid), 32'(eValid));
      checkOutput({tag, " busy"},  32'(busy),     32'(eValid));
      checkOutput({tag, " last"},  32'(so_last),  32'(eLast));
      checkOutput({tag, " ready"}, 32'(ready),    32'(eReady));
   endtask

   initial begin
      logic [3:0] rx;
      logic [7:0] stream;
      clear = 1'b0;
      applyStimulus(1'b0, 4'b0000);

      // Reset asserted between edges takes effect at once
      #2 clear = 1'b1;
      #1 checkCycle("reset", 1'b0, 1'b0, 1'b0, 1'b1);
      #1 clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkCycle($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
      end

`ifndef PISO_PARITY_EN
      // Single frame 1011, MSB first, looped back into a left-shifting receiver
      rx = 4'b0000;
      applyStimulus(1'b1, 4'b1011);
      tick();
      applyStimulus(1'b0, 4'b0000);
      checkCycle("single c1", 1'b1, 1'b1, 1'b0, 1'b0);
      rx = {rx[2:0], so};
      tick();
      checkCycle("single c2", 1'b0, 1'b1, 1'b0, 1'b0);
      rx = {rx[2:0], so};
      tick();
      checkCycle("single c3", 1'b1, 1'b1, 1'b0, 1'b0);
      rx = {rx[2:0], so};
      tick();
      checkCycle("single c4", 1'b1, 1'b1, 1'b1, 1'b1);
      rx = {rx[2:0], so};
      checkOutput("single rx", 32'(rx), 32'h0000_000B);
      tick();
      checkCycle("single idle", 1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back: 1011 then 0110 with load held, no gap between them
      stream = 8'b1011_0110;
      applyStimulus(1'b1, 4'b1011);
      tick();
      applyStimulus(1'b1, 4'b0110);
      for (int i = 0; i < 8; i++) begin
         checkCycle($sformatf("b2b c%0d", i + 1), stream[7 - i], 1'b1,
                    (i == 3) || (i == 7), (i == 3) || (i == 7));
         if (i == 6) applyStimulus(1'b0, 4'b0000);
         tick();
      end
      checkCycle("b2b idle", 1'b0, 1'b0, 1'b0, 1'b1);

      // Load while not ready is ignored; the frame 1100 is unaffected
      applyStimulus(1'b1, 4'b1100);
      tick();
      applyStimulus(1'b0, 4'b0000);
      checkCycle("ign c1", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 4'b0011);
      checkCycle("ign c2", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 4'b0000);
      checkCycle("ign c3", 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checkCycle("ign c4", 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      checkCycle("ign idle", 1'b0, 1'b0, 1'b0, 1'b1);

      // Clear after two bits of 1111 aborts the frame immediately
      applyStimulus(1'b1, 4'b1111);
      tick();
      applyStimulus(1'b0, 4'b0000);
      checkCycle("clr c1", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      checkCycle("clr c2", 1'b1, 1'b1, 1'b0, 1'b0);
      #2 clear = 1'b1;
      #1 checkCycle("clr abort", 1'b0, 1'b0, 1'b0, 1'b1);
      #1 clear = 1'b0;
      tick();
      checkCycle("clr after", 1'b0, 1'b0, 1'b0, 1'b1);

      // A fresh frame 0101 after the abort comes out whole
      applyStimulus(1'b1, 4'b0101);
      tick();
      applyStimulus(1'b0, 4'b0000);
      checkCycle("post c1", 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checkCycle("post c2", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      checkCycle("post c3", 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checkCycle("post c4", 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      checkCycle("post idle", 1'b0, 1'b0, 1'b0, 1'b1);
`else
      // Parity frame 1011, LSB first: data 1,1,0,1 then parity 1.
      // An LSB-first receiver shifts right, taking so into bit 3.
      rx = 4'b0000;
      stream = 8'b0000_1011;
      applyStimulus(1'b1, 4'b1011);
      tick();
      applyStimulus(1'b0, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         checkCycle($sformatf("par c%0d", i + 1), stream[i], 1'b1, 1'b0, 1'b0);
         if (so_valid && !so_last) rx = {so, rx[3:1]};
         tick();
      end
      checkCycle("par c5", 1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("par rx", 32'(rx), 32'h0000_000B);
      tick();
      checkCycle("par idle", 1'b0, 1'b0, 1'b0, 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
